// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I control path: FSM states, opcodes,
// and the datapath select encodings driven by the control FSM.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP,
    S_LUI,
    S_AUIPC
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // States that hold mem_req and may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) ||
           (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Combinational opcode -> immediate-format decode, shared with
// the single-cycle core. Ports: op_i (instr[6:0]), imm_src_o.
module imm_src_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_LOAD,
      OP_ITYPE:  imm_src_o = IMM_I;
      OP_STORE:  imm_src_o = IMM_S;
      OP_BRANCH: imm_src_o = IMM_B;
      OP_JAL:    imm_src_o = IMM_J;
      OP_LUI,
      OP_AUIPC:  imm_src_o = IMM_U;
      default:   imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/
// mem/writeback, drives datapath selects and strobes, stalls on the
// mem_req/mem_ready handshake, traps on illegal opcode or memory
// timeout (sticky illegal/timeout) and counts retired instructions.
// Inputs: clk, reset (sync, active-high), op, mem_ready.
// Outputs: mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite,
// AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal,
// timeout, instret.
// Optional macro RV_UPPER_IMM_EN adds LUI/AUIPC execute states.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [2:0]           ImmSrc,
  output logic                 illegal,
  output logic                 timeout,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned CNT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 mem_wait;

  imm_src_dec u_imm_src_dec (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      instret_q  <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    instret_d  = instret_q;
    mem_wait   = is_mem_state(state_q) && !mem_ready;
    // Non-mem states and completed accesses leave the counter at
    // zero, so entry into a mem state always starts from zero.
    wait_cnt_d = mem_wait ? wait_cnt_q + 1'b1 : '0;
    unique case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BEQ;
          OP_JAL:    state_d = S_JAL;
`ifdef RV_UPPER_IMM_EN
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d   = S_FETCH;
          instret_d = instret_q + 1'b1;
        end
      end
      S_MEMWB,
      S_ALUWB,
      S_BEQ: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 1'b1;
      end
      S_EXECR,
      S_EXECI,
      S_JAL:   state_d = S_ALUWB;
`ifdef RV_UPPER_IMM_EN
      S_LUI,
      S_AUIPC: state_d = S_ALUWB;
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // A completing access in the last allowed cycle wins.
    if (mem_wait && (wait_cnt_q == CNT_MAX)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALU_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALU_SUB;
        Branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
      end
`ifdef RV_UPPER_IMM_EN
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
`endif
      default: ;
    endcase
    // The state register is still pre-reset here; suppress strobes.
    if (reset) begin
      mem_req  = 1'b0;
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed scenarios plus a random
// instruction mix checked against a per-instruction phase model.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 16;
  localparam int IW = 32;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;

  logic clk = 1'b0;
  logic reset, mem_ready;
  logic [6:0] op;
  logic mem_req, PCUpdate, Branch, RegWrite;
  logic MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic illegal, timeout;
  logic [IW-1:0] instret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT (TO),
    .INSTRET_W   (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal),
    .timeout   (timeout),
    .instret   (instret)
  );

  // s = {req, pcu, br, rw, mw, irw, adr}
  typedef struct packed {
    logic [6:0] s;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aop;
  } cw_t;

  function automatic cw_t cw(input logic [6:0] s,
                             input logic [1:0] res,
                             input logic [1:0] a,
                             input logic [1:0] b,
                             input logic [1:0] aop);
    return {s, res, a, b, aop};
  endfunction

  localparam cw_t C_FWAIT = cw(7'b1000000, 2, 0, 2, 0);
  localparam cw_t C_FDONE = cw(7'b1100010, 2, 0, 2, 0);
  localparam cw_t C_DEC   = cw(7'b0000000, 0, 1, 1, 0);
  localparam cw_t C_MADR  = cw(7'b0000000, 0, 2, 1, 0);
  localparam cw_t C_MRD   = cw(7'b1000001, 0, 0, 0, 0);
  localparam cw_t C_MWB   = cw(7'b0001000, 1, 0, 0, 0);
  localparam cw_t C_MWW   = cw(7'b1000001, 0, 0, 0, 0);
  localparam cw_t C_MWD   = cw(7'b1000101, 0, 0, 0, 0);
  localparam cw_t C_EXR   = cw(7'b0000000, 0, 2, 0, 2);
  localparam cw_t C_EXI   = cw(7'b0000000, 0, 2, 1, 2);
  localparam cw_t C_ALUWB = cw(7'b0001000, 0, 0, 0, 0);
  localparam cw_t C_BEQ   = cw(7'b0010000, 0, 2, 0, 1);
  localparam cw_t C_JAL   = cw(7'b0100000, 0, 1, 2, 0);
  localparam cw_t C_TRAP  = cw(7'b0000000, 0, 0, 0, 0);

  function automatic cw_t dut_cw();
    return {mem_req, PCUpdate, Branch, RegWrite, MemWrite,
            IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    case (o)
      ST:       return 3'd1;
      BR:       return 3'd2;
      JL:       return 3'd3;
      LUI, AUI: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  // Model: each instruction expands to a list of cycles, each with
  // the mem_ready to drive, the expected control word, and whether
  // the instruction retires at the end of that cycle.
  logic [6:0] q_op [$];
  logic       q_rdy [$];
  cw_t        q_cw [$];
  bit         q_ret [$];

  task automatic push(input logic [6:0] o, input logic r,
                      input cw_t c, input bit ret);
    q_op.push_back(o);
    q_rdy.push_back(r);
    q_cw.push_back(c);
    q_ret.push_back(ret);
  endtask

  task automatic plan(input logic [6:0] o, input int wf,
                      input int wm);
    repeat (wf) push(o, 1'b0, C_FWAIT, 0);
    push(o, 1'b1, C_FDONE, 0);
    push(o, 1'($urandom), C_DEC, 0);
    case (o)
      LD: begin
        push(o, 1'($urandom), C_MADR, 0);
        repeat (wm) push(o, 1'b0, C_MRD, 0);
        push(o, 1'b1, C_MRD, 0);
        push(o, 1'($urandom), C_MWB, 1);
      end
      ST: begin
        push(o, 1'($urandom), C_MADR, 0);
        repeat (wm) push(o, 1'b0, C_MWW, 0);
        push(o, 1'b1, C_MWD, 1);
      end
      RT: begin
        push(o, 1'($urandom), C_EXR, 0);
        push(o, 1'($urandom), C_ALUWB, 1);
      end
      IT: begin
        push(o, 1'($urandom), C_EXI, 0);
        push(o, 1'($urandom), C_ALUWB, 1);
      end
      BR: push(o, 1'($urandom), C_BEQ, 1);
      default: begin
        push(o, 1'($urandom), C_JAL, 0);
        push(o, 1'($urandom), C_ALUWB, 1);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = RT;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (dut_cw().s[6:1] !== 6'b0) begin
        fails++;
        $display("FAIL reset_strobes cyc%0d got %b want 0",
                 i, dut_cw().s[6:1]);
      end
      tick();
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_cw() !== C_FWAIT) begin
      fails++;
      $display("FAIL reset_fetch got %h want %h",
               dut_cw(), C_FWAIT);
    end
    tests++;
    if ({illegal, timeout, instret} !== '0) begin
      fails++;
      $display("FAIL reset_regs got %b %b %0d want 0 0 0",
               illegal, timeout, instret);
    end
    tick();
  endtask

  task automatic test_rtype();
    cw_t exp [5];
    exp = '{C_FDONE, C_DEC, C_EXR, C_ALUWB, C_FWAIT};
    do_reset();
    op = RT;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      @(negedge clk);
      tests++;
      if (dut_cw() !== exp[i]) begin
        fails++;
        $display("FAIL rtype cyc%0d got %h want %h",
                 i, dut_cw(), exp[i]);
      end
      tests++;
      if (instret !== IW'(i == 4)) begin
        fails++;
        $display("FAIL rtype_instret cyc%0d got %0d want %0d",
                 i, instret, (i == 4));
      end
      tick();
    end
  endtask

  task automatic test_load_stall();
    cw_t  exp [9];
    logic rdy [9];
    int   req_n, rw_n;
    exp = '{C_FDONE, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD,
            C_MRD, C_MWB, C_FWAIT};
    rdy = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
    req_n = 0;
    rw_n = 0;
    do_reset();
    op = LD;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      if (i >= 2 && i <= 7 && mem_req) req_n++;
      if (RegWrite) rw_n++;
      tests++;
      if (dut_cw() !== exp[i]) begin
        fails++;
        $display("FAIL load cyc%0d got %h want %h",
                 i, dut_cw(), exp[i]);
      end
      tick();
    end
    tests++;
    if (req_n != 4 || rw_n != 1 || instret !== IW'(1)) begin
      fails++;
      $display("FAIL load_counts req %0d rw %0d ret %0d want 4 1 1",
               req_n, rw_n, instret);
    end
  endtask

  task automatic test_store();
    cw_t  exp [7];
    logic rdy [7];
    exp = '{C_FDONE, C_DEC, C_MADR, C_MWW, C_MWW,
            C_MWD, C_FWAIT};
    rdy = '{1, 0, 1, 0, 0, 1, 0};
    do_reset();
    op = ST;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      tests++;
      if (dut_cw() !== exp[i]) begin
        fails++;
        $display("FAIL store cyc%0d got %h want %h",
                 i, dut_cw(), exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    cw_t exp [4];
    exp = '{C_FDONE, C_DEC, C_BEQ, C_FWAIT};
    do_reset();
    op = BR;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      @(negedge clk);
      tests++;
      if (dut_cw() !== exp[i] || ImmSrc !== 3'd2) begin
        fails++;
        $display("FAIL beq cyc%0d got %h/%0d want %h/2",
                 i, dut_cw(), ImmSrc, exp[i]);
      end
      tick();
    end
    tests++;
    if (instret !== IW'(1)) begin
      fails++;
      $display("FAIL beq_instret got %0d want 1", instret);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad [3];
    int n;
    bad = '{7'h7f, LUI, AUI};
`ifdef RV_UPPER_IMM_EN
    n = 1;
`else
    n = 3;
`endif
    for (int k = 0; k < n; k++) begin
      do_reset();
      op = bad[k];
      mem_ready = 1'b1;
      tick();
      @(negedge clk);
      tests++;
      if (dut_cw() !== C_DEC || illegal !== 1'b0) begin
        fails++;
        $display("FAIL ill_decode op%h got %h/%b want %h/0",
                 bad[k], dut_cw(), illegal, C_DEC);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
        mem_ready = 1'($urandom);
        @(negedge clk);
        tests++;
        if (dut_cw() !== C_TRAP || illegal !== 1'b1 ||
            timeout !== 1'b0) begin
          fails++;
          $display("FAIL ill_trap op%h cyc%0d got %h %b%b",
                   bad[k], i, dut_cw(), illegal, timeout);
        end
        tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (dut_cw() !== C_FWAIT || illegal !== 1'b0) begin
        fails++;
        $display("FAIL ill_recover got %h/%b want %h/0",
                 dut_cw(), illegal, C_FWAIT);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    op = RT;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (i < TO) begin
        if (dut_cw() !== C_FWAIT || timeout !== 1'b0) begin
          fails++;
          $display("FAIL tmo_wait cyc%0d got %h/%b",
                   i, dut_cw(), timeout);
        end
      end else if (dut_cw() !== C_TRAP || timeout !== 1'b1 ||
                   illegal !== 1'b0) begin
        fails++;
        $display("FAIL tmo_trap cyc%0d got %h/%b%b want 0/10",
                 i, dut_cw(), timeout, illegal);
      end
      tick();
    end
    // Ready arriving on the final allowed cycle must win.
    do_reset();
    for (int i = 0; i < TO + 1; i++) begin
      mem_ready = (i == TO - 1);
      @(negedge clk);
      tests++;
      if (i == TO) begin
        if (dut_cw() !== C_DEC || timeout !== 1'b0) begin
          fails++;
          $display("FAIL tmo_edge got %h/%b want %h/0",
                   dut_cw(), timeout, C_DEC);
        end
      end else if (dut_cw() !== ((i == TO - 1) ? C_FDONE
                                              : C_FWAIT)) begin
        fails++;
        $display("FAIL tmo_edge_fetch cyc%0d got %h",
                 i, dut_cw());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op = ST;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (MemWrite !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got mw %b req %b want 0 0",
               MemWrite, mem_req);
    end
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_cw() !== C_FWAIT || instret !== '0) begin
      fails++;
      $display("FAIL rst_mid_fetch got %h/%0d want %h/0",
               dut_cw(), instret, C_FWAIT);
    end
    tick();
  endtask

`ifdef RV_UPPER_IMM_EN
  task automatic test_upper_imm();
    logic [6:0] ops [2];
    cw_t mid [2];
    cw_t exp [5];
    ops = '{LUI, AUI};
    mid = '{cw(7'b0, 0, 3, 1, 0), cw(7'b0, 0, 1, 1, 0)};
    for (int k = 0; k < 2; k++) begin
      exp = '{C_FDONE, C_DEC, mid[k], C_ALUWB, C_FWAIT};
      do_reset();
      op = ops[k];
      for (int i = 0; i < 5; i++) begin
        mem_ready = (i == 0);
        @(negedge clk);
        tests++;
        if (dut_cw() !== exp[i] || ImmSrc !== 3'd4 ||
            illegal !== 1'b0) begin
          fails++;
          $display("FAIL upper op%h cyc%0d got %h want %h",
                   ops[k], i, dut_cw(), exp[i]);
        end
        tick();
      end
    end
  endtask
`endif

  task automatic test_random_mix();
    logic [6:0] ops [6];
    logic [6:0] o;
    cw_t e;
    bit r;
    int ret;
    ops = '{LD, ST, RT, IT, BR, JL};
    ret = 0;
    for (int n = 0; n < 40; n++)
      plan(ops[$urandom_range(0, 5)], $urandom_range(0, 4),
           $urandom_range(0, 4));
    do_reset();
    while (q_cw.size() > 0) begin
      o = q_op.pop_front();
      op = o;
      mem_ready = q_rdy.pop_front();
      e = q_cw.pop_front();
      r = q_ret.pop_front();
      @(negedge clk);
      tests++;
      if (dut_cw() !== e) begin
        fails++;
        $display("FAIL mix_cw op%h got %h want %h",
                 o, dut_cw(), e);
      end
      tests++;
      if (ImmSrc !== imm_ref(o) || instret !== IW'(ret) ||
          illegal !== 1'b0 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL mix_st op%h imm %0d/%0d ret %0d/%0d %b%b",
                 o, ImmSrc, imm_ref(o), instret, ret,
                 illegal, timeout);
      end
      tick();
      if (r) ret++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    op = '0;
    test_reset();
    test_rtype();
    test_load_stall();
    test_store();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
`ifdef RV_UPPER_IMM_EN
    test_upper_imm();
`endif
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
